reg_dump_streamer: RTL and testbench

- Automated consumer of the CPU's register debug port (reg_sel out, reg_data in). It replaces manual poking of reg_sel by the bench.
- On a start pulse it sweeps reg_sel over a configured register range and samples reg_data for each register.
- Each register is streamed out as 4 bytes, MSB first, over a valid/ready byte interface. A UART transmitter or a bench monitor sits on that interface.
- Sits beside sccomp at the top level, clocked with the CPU.

---
 rtl/cpu_dbg_pkg.sv | 18 +
 rtl/byte_serializer.sv | 45 ++++
 rtl/reg_dump_streamer.sv | 114 +++++++++++
 tb/tb_reg_dump_streamer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU register-dump streamer.
package cpu_dbg_pkg;

  localparam int unsigned REG_IDX_W      = 5;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned SETTLE_W       = 4;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/byte_serializer.sv
// Loads a word and emits it as bytes, MSB first, under a valid/ready handshake.
module byte_serializer
  import cpu_dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_ready,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last_acc_c
);

  logic [WORD_W-1:0]     r_shift;
  logic [BYTE_CNT_W-1:0] r_cnt;
  logic                  r_valid;
  logic                  w_acc;

  assign w_acc        = r_valid && i_ready;
  assign o_last_acc_c = w_acc && (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign o_data       = r_shift[WORD_W-1 -: BYTE_W];
  assign o_valid      = r_valid;

  // Shift register: load on capture, advance one byte per accepted transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_acc) begin
      if (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1)) begin
        r_valid <= 1'b0;
      end else begin
        r_shift <= {r_shift[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
        r_cnt   <= r_cnt + BYTE_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reg_dump_streamer.sv
// Sweeps the CPU register debug port and streams each register as 4 bytes.
module reg_dump_streamer
  import cpu_dbg_pkg::*;
#(
  parameter int unsigned START_REG = 0,
  parameter int unsigned END_REG   = 31,
  parameter int unsigned SETTLE    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic [REG_IDX_W-1:0] reg_sel,
  input  logic [WORD_W-1:0]    reg_data,
  output logic [BYTE_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  // Reject configurations the sweep cannot represent.
  if (END_REG < START_REG || END_REG > 31 || SETTLE < 1 || SETTLE > 15) begin : g_cfg_check
    $error("reg_dump_streamer: illegal START_REG/END_REG/SETTLE");
  end

  dump_state_e          r_state,   w_state;
  logic [REG_IDX_W-1:0] r_reg_sel, w_reg_sel;
  logic [SETTLE_W-1:0]  r_settle,  w_settle;
  logic                 r_busy,    w_busy;
  logic                 r_done,    w_done;
  logic                 w_load;
  logic                 w_last_acc;

  // Registers for the sweep FSM and its registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_reg_sel <= '0;
      r_settle  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_reg_sel <= w_reg_sel;
      r_settle  <= w_settle;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  // Next-state logic: settle on each register, capture, then wait for its last byte.
  always_comb begin
    w_state   = r_state;
    w_reg_sel = r_reg_sel;
    w_settle  = r_settle;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state   = ST_SEL;
          w_reg_sel = REG_IDX_W'(START_REG);
          w_settle  = SETTLE_W'(SETTLE);
          w_busy    = 1'b1;
        end
      end
      ST_SEL: begin
        if (r_settle == '0) begin
          w_load  = 1'b1;
          w_state = ST_SEND;
        end else begin
          w_settle = r_settle - SETTLE_W'(1);
        end
      end
      ST_SEND: begin
        if (w_last_acc) begin
          if (r_reg_sel == REG_IDX_W'(END_REG)) begin
            w_state   = ST_FIN;
            w_reg_sel = '0;
            w_busy    = 1'b0;
            w_done    = 1'b1;
          end else begin
            w_state   = ST_SEL;
            w_reg_sel = r_reg_sel + REG_IDX_W'(1);
            w_settle  = SETTLE_W'(SETTLE);
          end
        end
      end
      ST_FIN: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  byte_serializer u_ser (
    .clk          (clk),
    .rstn         (rstn),
    .i_load       (w_load),
    .i_word       (reg_data),
    .i_ready      (out_ready),
    .o_data       (out_data),
    .o_valid      (out_valid),
    .o_last_acc_c (w_last_acc)
  );

  assign reg_sel = r_reg_sel;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed bench for reg_dump_streamer: default sweep plus a single-register config.
module tb_reg_dump_streamer;

  logic        clk;
  logic        rstn;
  logic        start,     start2;
  logic [4:0]  reg_sel,   reg_sel2;
  logic [31:0] reg_data,  reg_data2;
  logic [7:0]  out_data,  out_data2;
  logic        out_valid, out_valid2;
  logic        out_ready, out_ready2;
  logic        busy,      busy2;
  logic        done,      done2;
  logic        ov_en;

  typedef struct {
    int         idx;
    logic [7:0] exp_data;
    logic [4:0] exp_sel;
  } vec_t;

  vec_t        tbl [8];
  int          n_vec, n_err;
  logic [7:0]  q_data [$];
  logic [4:0]  q_sel  [$];
  logic [7:0]  q2     [$];
  int          n_done, n_done2;
  bit          done_after_acc, busy_at_done;
  logic [4:0]  sel_at_done;
  int          bytes_at_done;

  // Register file model; ov_en corrupts register 5 after it has been captured.
  assign reg_data  = (ov_en && reg_sel == 5'd5) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(reg_sel));
  assign reg_data2 = 32'h0000_0007;

  reg_dump_streamer u_dut (
    .clk(clk), .rstn(rstn), .start(start), .reg_sel(reg_sel), .reg_data(reg_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  reg_dump_streamer #(.START_REG(7), .END_REG(7), .SETTLE(3)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .reg_sel(reg_sel2), .reg_data(reg_data2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int idx);
    logic [31:0] w;
    w = 32'hA500_0000 | 32'(idx / 4);
    return 8'(w >> (8 * (3 - (idx % 4))));
  endfunction

  // One clock: log accepted bytes before the edge, observe outputs 1 ns after it.
  task automatic tick();
    bit a, a2;
    a  = (out_valid === 1'b1) && (out_ready === 1'b1);
    a2 = (out_valid2 === 1'b1) && (out_ready2 === 1'b1);
    if (a) begin
      q_data.push_back(out_data);
      q_sel.push_back(reg_sel);
    end
    if (a2) q2.push_back(out_data2);
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      n_done++;
      done_after_acc = a;
      busy_at_done   = busy;
      sel_at_done    = reg_sel;
      bytes_at_done  = q_data.size();
    end
    if (done2 === 1'b1) n_done2++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int c;
    d0 = n_done;
    c  = 0;
    while (n_done == d0 && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_done_seen"}, 32'(n_done - d0), 32'd1);
  endtask

  task automatic check_table(input string tag);
    chk({tag, "_byte_count"}, 32'(q_data.size()), 32'd128);
    foreach (tbl[i]) begin
      if (tbl[i].idx < q_data.size()) begin
        chk($sformatf("%s_data_%0d", tag, tbl[i].idx), 32'(q_data[tbl[i].idx]), 32'(tbl[i].exp_data));
        chk($sformatf("%s_sel_%0d", tag, tbl[i].idx), 32'(q_sel[tbl[i].idx]), 32'(tbl[i].exp_sel));
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL %s_missing_%0d: got %0d bytes required more", tag, tbl[i].idx, q_data.size());
      end
    end
  endtask

  task automatic check_stream(input string tag);
    int bad;
    bad = 0;
    foreach (q_data[i]) if (q_data[i] !== exp_byte(i) || q_sel[i] !== 5'(i / 4)) bad++;
    chk({tag, "_stream_errors"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int  c;
    int  d0;
    bit  bp_done, rs_done;

    tbl[0] = '{0,   8'hA5, 5'd0};
    tbl[1] = '{1,   8'h00, 5'd0};
    tbl[2] = '{3,   8'h00, 5'd0};
    tbl[3] = '{28,  8'hA5, 5'd7};
    tbl[4] = '{29,  8'h00, 5'd7};
    tbl[5] = '{30,  8'h00, 5'd7};
    tbl[6] = '{31,  8'h07, 5'd7};
    tbl[7] = '{127, 8'h1F, 5'd31};

    n_vec = 0; n_err = 0; n_done = 0; n_done2 = 0;
    start = 0; start2 = 0; out_ready = 0; out_ready2 = 0; ov_en = 0;
    rstn = 1;
    #1 rstn = 0;
    #1;
    chk("rst_reg_sel",   32'(reg_sel),   32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_busy2",     32'(busy2),     32'd0);
    repeat (2) tick();
    rstn = 1;
    tick();

    // Sweep 1: defaults, sink always ready
    out_ready = 1;
    start = 1;
    tick();
    start = 0;
    chk("s1_busy_after_start", 32'(busy),      32'd1);
    chk("s1_sel_after_start",  32'(reg_sel),   32'd0);
    chk("s1_valid_k",          32'(out_valid), 32'd0);
    tick();
    chk("s1_valid_k1",         32'(out_valid), 32'd0);
    tick();
    chk("s1_valid_k2",         32'(out_valid), 32'd1);
    chk("s1_first_byte",       32'(out_data),  32'hA5);
    wait_done("s1", 600);
    chk("s1_bytes_at_done", 32'(bytes_at_done),  32'd128);
    chk("s1_done_after_acc", 32'(done_after_acc), 32'd1);
    chk("s1_busy_at_done",  32'(busy_at_done),   32'd0);
    chk("s1_sel_at_done",   32'(sel_at_done),    32'd0);
    check_table("s1");
    check_stream("s1");

    // start held through FIN (ignored) and into the following IDLE cycle (accepted)
    q_data.delete();
    q_sel.delete();
    start = 1;
    tick();
    chk("fin_done_one_cycle", 32'(done), 32'd0);
    chk("fin_start_ignored",  32'(busy), 32'd0);
    tick();
    start = 0;
    chk("idle_after_fin_start", 32'(busy), 32'd1);

    // Sweep 2: backpressure on reg 3 byte 2, restart attempt on reg 10, reg 5 changed after capture
    bp_done = 0; rs_done = 0; c = 0; d0 = n_done;
    while (n_done == d0 && c < 3000) begin
      if (!bp_done && q_data.size() == 13 && out_valid) begin
        out_ready = 0;
        repeat (5) begin
          tick();
          chk("bp_data",  32'(out_data),  32'h00);
          chk("bp_sel",   32'(reg_sel),   32'd3);
          chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1;
        bp_done   = 1;
      end
      if (q_data.size() == 20 && out_valid) ov_en = 1;
      else if (q_data.size() >= 24) ov_en = 0;
      if (!rs_done && reg_sel == 5'd10 && busy) begin
        start = 1;
        tick();
        start   = 0;
        rs_done = 1;
      end else begin
        tick();
      end
      c++;
    end
    ov_en = 0;
    chk("s2_done_seen",     32'(n_done - d0),   32'd1);
    chk("s2_bytes_at_done", 32'(bytes_at_done), 32'd128);
    check_table("s2");
    check_stream("s2");
    repeat (3) tick();
    chk("s2_single_done", 32'(n_done), 32'd2);

    // Sweep 3: reset during SEND of reg 12, then a clean sweep
    q_data.delete();
    q_sel.delete();
    start = 1;
    tick();
    start = 0;
    c = 0;
    while (!(reg_sel == 5'd12 && out_valid) && c < 500) begin
      tick();
      c++;
    end
    chk("s3_reach_reg12", 32'(reg_sel), 32'd12);
    d0 = n_done;
    rstn = 0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_reg_sel",   32'(reg_sel),   32'd0);
    chk("abort_out_data",  32'(out_data),  32'd0);
    repeat (2) tick();
    rstn = 1;
    tick();
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    q_data.delete();
    q_sel.delete();
    start = 1;
    tick();
    start = 0;
    wait_done("s3", 600);
    check_table("s3");

    // Single-register config: START=END=7, SETTLE=3
    start2 = 1;
    tick();
    start2 = 0;
    chk("r_sel_k",   32'(reg_sel2),   32'd7);
    chk("r_valid_k", 32'(out_valid2), 32'd0);
    chk("r_busy_k",  32'(busy2),      32'd1);
    repeat (2) begin
      tick();
      chk("r_sel_settle",   32'(reg_sel2),   32'd7);
      chk("r_valid_settle", 32'(out_valid2), 32'd0);
    end
    out_ready2 = 1;
    d0 = n_done2;
    c  = 0;
    while (n_done2 == d0 && c < 50) begin
      tick();
      c++;
    end
    chk("r_done_seen",      32'(n_done2 - d0), 32'd1);
    chk("r_byte_count",     32'(q2.size()),    32'd4);
    chk("r_sel_after_done", 32'(reg_sel2),     32'd0);
    chk("r_busy_after_done", 32'(busy2),       32'd0);
    if (q2.size() == 4) begin
      chk("r_byte0", 32'(q2[0]), 32'h00);
      chk("r_byte1", 32'(q2[1]), 32'h00);
      chk("r_byte2", 32'(q2[2]), 32'h00);
      chk("r_byte3", 32'(q2[3]), 32'h07);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
